// File: rtl/note_timer_pkg.sv
// note_timer_pkg: length codes, FSM states and code-to-ticks helper
// shared by the tempo-driven note timer and its divider.
package note_timer_pkg;

  localparam logic [3:0] LEN_NONE    = 4'd0;
  localparam logic [3:0] LEN_WHOLE   = 4'd1;
  localparam logic [3:0] LEN_HALF    = 4'd2;
  localparam logic [3:0] LEN_QUARTER = 4'd3;
  localparam logic [3:0] LEN_EIGHTH  = 4'd4;
  localparam logic [3:0] LEN_D_HALF  = 4'd5;
  localparam logic [3:0] LEN_D_QUART = 4'd6;
  localparam logic [3:0] LEN_D_EIGHT = 4'd7;
  localparam logic [3:0] LEN_SIXTEEN = 4'd8;
  localparam logic [3:0] LEN_T_QUART = 4'd9;
  localparam logic [3:0] LEN_T_EIGHT = 4'd10;

  // 4*PPQ reaches 240 for PPQ=60, so the count needs 8 bits
  localparam int TCNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // Note length in ticks; 0 for NONE and for invalid codes
  function automatic logic [TCNT_W-1:0] len_to_ticks(
    input logic [3:0] code,
    input int         ppq
  );
    int t;
    t = 0;
    case (code)
      LEN_WHOLE:   t = 4 * ppq;
      LEN_HALF:    t = 2 * ppq;
      LEN_QUARTER: t = ppq;
      LEN_EIGHTH:  t = ppq / 2;
      LEN_D_HALF:  t = 3 * ppq;
      LEN_D_QUART: t = (3 * ppq) / 2;
      LEN_D_EIGHT: t = (3 * ppq) / 4;
      LEN_SIXTEEN: t = ppq / 4;
      LEN_T_QUART: t = (2 * ppq) / 3;
      LEN_T_EIGHT: t = ppq / 3;
      default:     t = 0;
    endcase
    return TCNT_W'(t);
  endfunction

endpackage

// File: rtl/tempo_divider.sv
// tempo_divider: free-running 0..div counter with synchronous clear.
// Ports: clk, rst, clr, en, div (terminal count), tick (count==div).
module tempo_divider #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = (cnt_q == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/note_duration_timer.sv
// note_duration_timer: times notes in tempo ticks, drives gate/strobes.
// Ports: note handshake in, tick_div tempo, pause/stop, gate/tick/status out.
module note_duration_timer
  import note_timer_pkg::*;
#(
  parameter int PPQ       = 24,
  parameter int DIV_W     = 24,
  parameter int GAP_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] tick_div,
  input  logic             in_valid,
  input  logic [3:0]       in_length,
  input  logic             in_rest,
  output logic             in_ready,
  input  logic             pause,
  input  logic             stop,
  output logic             gate,
  output logic             tick,
  output logic             note_change,
  output logic             busy,
  output logic             err_code
);

  localparam logic [TCNT_W-1:0] GAP = TCNT_W'(GAP_TICKS);

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    d_q, d_d;
  logic [TCNT_W-1:0]   len_q, len_d;
  logic [TCNT_W-1:0]   cnt_q, cnt_d;
  logic [TCNT_W-1:0]   cnt_inc;
  logic [TCNT_W-1:0]   code_len;
  logic                gate_q, gate_d;
  logic                nc_q, nc_d;
  logic                err_q, err_d;
  logic                accept;
  logic                div_tick;
  logic                div_clr;
  logic                div_en;

  assign in_ready    = (state_q == IDLE) && !stop;
  assign busy        = (state_q == PLAY);
  assign tick        = busy && div_tick && !pause;
  assign gate        = gate_q;
  assign note_change = nc_q;
  assign err_code    = err_q;

  assign accept   = in_valid && in_ready;
  assign code_len = len_to_ticks(in_length, PPQ);
  assign cnt_inc  = cnt_q + 1'b1;

  // Divider only runs in PLAY; held at 0 in IDLE so a new
  // note always starts from a fresh tick period.
  assign div_clr = (state_q != PLAY) || stop;
  assign div_en  = (state_q == PLAY) && !pause;

  tempo_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (div_en),
    .div  (d_q),
    .tick (div_tick)
  );

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gate_d  = gate_q;
    nc_d    = 1'b0;
    err_d   = 1'b0;
    unique case (1'b1)
      stop: begin
        state_d = IDLE;
        cnt_d   = '0;
        gate_d  = 1'b0;
      end
      (!stop && state_q == IDLE): begin
        if (accept) begin
          if (code_len != '0) begin
            state_d = PLAY;
            d_d     = tick_div;
            len_d   = code_len;
            cnt_d   = '0;
            gate_d  = !in_rest && (code_len > GAP);
          end else if (in_length > LEN_T_EIGHT) begin
            err_d = 1'b1;
          end
        end
      end
      (!stop && state_q == PLAY): begin
        if (div_tick && !pause) begin
          cnt_d = cnt_inc;
          // Articulation gap: release the gate after tick L-GAP
          if (cnt_inc == len_q - GAP) begin
            gate_d = 1'b0;
          end
          if (cnt_inc == len_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            gate_d  = 1'b0;
            nc_d    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      nc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      nc_q    <= nc_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_note_duration_timer.sv
// tb_note_duration_timer: directed and random checks of note timing
// against an elapsed-cycle reference model.
module tb_note_duration_timer;

  localparam int P = 24;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] tick_div;
  logic        in_valid;
  logic [3:0]  in_length;
  logic        in_rest;
  logic        in_ready;
  logic        pause;
  logic        stop;
  logic        gate;
  logic        tick;
  logic        note_change;
  logic        busy;
  logic        err_code;

  always #5 clk = ~clk;

  note_duration_timer #(
    .PPQ       (24),
    .DIV_W     (24),
    .GAP_TICKS (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_div    (tick_div),
    .in_valid    (in_valid),
    .in_length   (in_length),
    .in_rest     (in_rest),
    .in_ready    (in_ready),
    .pause       (pause),
    .stop        (stop),
    .gate        (gate),
    .tick        (tick),
    .note_change (note_change),
    .busy        (busy),
    .err_code    (err_code)
  );

  int n_pass;
  int n_fail;
  int n_checks;
  int cyc;

  // reference model: a note needs L*(D+1) unpaused cycles
  bit m_busy;
  bit m_rest;
  bit m_nc;
  bit m_err;
  int m_e;
  int m_len;
  int m_d;

  int gate_cnt;
  int tick_cnt;
  int nc_cnt;
  int err_cnt;
  int busy_cnt;
  int nc_cyc;
  int err_cyc;
  int rise_cyc;
  int fall_cyc;
  bit prev_gate;
  int t0;

  function automatic int ref_len(input int code);
    case (code)
      1:       return 4 * P;
      2:       return 2 * P;
      3:       return P;
      4:       return P / 2;
      5:       return 3 * P;
      6:       return 3 * P / 2;
      7:       return 3 * P / 4;
      8:       return P / 4;
      9:       return 2 * P / 3;
      10:      return P / 3;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_rest = 0;
    m_nc   = 0;
    m_err  = 0;
    m_e    = 0;
    m_len  = 0;
    m_d    = 0;
  endtask

  task automatic clr_stats();
    gate_cnt = 0;
    tick_cnt = 0;
    nc_cnt   = 0;
    err_cnt  = 0;
    busy_cnt = 0;
    nc_cyc   = -1;
    err_cyc  = -1;
  endtask

  // Compare one cycle at the falling edge, then advance the model
  task automatic step();
    logic [5:0] obs;
    logic [5:0] exp;
    bit         eg;
    bit         et;
    int         l;
    @(negedge clk);
    eg = m_busy && !m_rest && (m_len > G) &&
         (m_e < (m_len - G) * (m_d + 1));
    et = m_busy && !pause && (((m_e + 1) % (m_d + 1)) == 0);
    exp = {!m_busy && !stop, m_busy, eg, et, m_nc, m_err};
    obs = {in_ready, busy, gate, tick, note_change, err_code};
    chk($sformatf("cycle%0d", cyc), int'(obs), int'(exp));
    if (gate) gate_cnt++;
    if (tick) tick_cnt++;
    if (busy) busy_cnt++;
    if (note_change) begin
      nc_cnt++;
      nc_cyc = cyc;
    end
    if (err_code) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (gate && !prev_gate) rise_cyc = cyc;
    if (!gate && prev_gate) fall_cyc = cyc;
    prev_gate = gate;
    m_nc  = 0;
    m_err = 0;
    if (stop) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        l = ref_len(int'(in_length));
        if (l > 0) begin
          m_busy = 1;
          m_e    = 0;
          m_len  = l;
          m_d    = int'(tick_div);
          m_rest = in_rest;
        end else if (in_length >= 4'd11) begin
          m_err = 1;
        end
      end
    end else if (!pause) begin
      m_e++;
      if (m_e == m_len * (m_d + 1)) begin
        m_busy = 0;
        m_nc   = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_pass    = 0;
    n_fail    = 0;
    n_checks  = 0;
    cyc       = 0;
    prev_gate = 0;
    rise_cyc  = -1;
    fall_cyc  = -1;
    rst       = 1'b1;
    tick_div  = 24'd3;
    in_valid  = 1'b0;
    in_length = 4'd0;
    in_rest   = 1'b0;
    pause     = 1'b0;
    stop      = 1'b0;
    model_reset();
    clr_stats();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs",
        int'({in_ready, busy, gate, tick, note_change, err_code}),
        int'(6'b100000));
    rst = 1'b0;
    repeat (2) step();

    // 1: quarter note, D=3
    clr_stats();
    t0 = cyc;
    in_valid  = 1'b1;
    in_length = 4'd3;
    step();
    in_valid = 1'b0;
    repeat (110) step();
    chk("q_nc_time", nc_cyc - t0, 97);
    chk("q_gate_cycles", gate_cnt, 88);
    chk("q_ticks", tick_cnt, 24);

    // 2: back-to-back eighth then half, valid held
    clr_stats();
    t0 = cyc;
    in_valid  = 1'b1;
    in_length = 4'd4;
    step();
    in_length = 4'd2;
    repeat (49) step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("b2b_nc_time", nc_cyc - t0, 49);
    chk("b2b_gap", rise_cyc - fall_cyc, 9);
    repeat (200) step();
    chk("b2b_notes", nc_cnt, 2);

    // 3: invalid code, then NONE
    clr_stats();
    t0 = cyc;
    in_valid  = 1'b1;
    in_length = 4'd12;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("inv_err_time", err_cyc - t0, 1);
    chk("inv_busy", busy_cnt, 0);
    chk("inv_nc", nc_cnt, 0);
    clr_stats();
    in_valid  = 1'b1;
    in_length = 4'd0;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("none_strobes", err_cnt + nc_cnt + tick_cnt + busy_cnt, 0);

    // 4: 50-cycle pause mid-quarter
    clr_stats();
    t0 = cyc;
    in_valid  = 1'b1;
    in_length = 4'd3;
    step();
    in_valid = 1'b0;
    repeat (40) step();
    pause = 1'b1;
    repeat (50) step();
    pause = 1'b0;
    repeat (70) step();
    chk("pause_nc_time", nc_cyc - t0, 147);
    chk("pause_gate", gate_cnt, 138);
    chk("pause_ticks", tick_cnt, 24);

    // 5: stop in PLAY, stop in IDLE, async reset, rest note
    clr_stats();
    in_valid  = 1'b1;
    in_length = 4'd3;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_gate", int'(gate), 0);
    repeat (10) step();
    chk("stop_nc", nc_cnt, 0);
    chk("stop_gate_cyc", gate_cnt, 21);
    stop      = 1'b1;
    in_valid  = 1'b1;
    in_length = 4'd4;
    step();
    stop     = 1'b0;
    in_valid = 1'b0;
    chk("stop_idle_busy", int'(busy), 0);
    step();
    clr_stats();
    in_valid  = 1'b1;
    in_length = 4'd3;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("pre_rst_gate", int'(gate), 1);
    rst = 1'b1;
    #1;
    chk("async_rst",
        int'({in_ready, busy, gate, tick, note_change, err_code}),
        int'(6'b100000));
    model_reset();
    #1;
    rst = 1'b0;
    repeat (5) step();
    chk("rst_nc", nc_cnt, 0);
    clr_stats();
    tick_div  = 24'd1;
    t0        = cyc;
    in_valid  = 1'b1;
    in_length = 4'd4;
    in_rest   = 1'b1;
    step();
    in_valid = 1'b0;
    in_rest  = 1'b0;
    repeat (30) step();
    chk("rest_gate", gate_cnt, 0);
    chk("rest_nc_time", nc_cyc - t0, 25);

    // 6: tempo change mid-note, then triplet eighth
    clr_stats();
    tick_div  = 24'd3;
    t0        = cyc;
    in_valid  = 1'b1;
    in_length = 4'd4;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    tick_div = 24'd1;
    repeat (50) step();
    chk("dchg_nc_time", nc_cyc - t0, 49);
    clr_stats();
    t0        = cyc;
    in_valid  = 1'b1;
    in_length = 4'd10;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    chk("trip8_nc_time", nc_cyc - t0, 17);
    chk("trip8_ticks", tick_cnt, 8);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_length = 4'($urandom_range(0, 15));
      in_rest   = ($urandom_range(0, 3) == 0);
      pause     = ($urandom_range(0, 9) == 0);
      stop      = ($urandom_range(0, 49) == 0);
      tick_div  = 24'($urandom_range(0, 2));
      step();
    end
    in_valid = 1'b0;
    pause    = 1'b0;
    stop     = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
